// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the Wishbone-to-RAM controller.
package ram_ctrl_pkg;

  localparam int unsigned BYTE_LANES = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    ACK   = 3'd4,
    ERR   = 3'd5
  } ctrl_state_e;

  // Per-lane select: set lanes take the new byte, clear lanes keep the old one.
  function automatic logic [31:0] byte_merge(input logic [31:0]           old_w,
                                             input logic [31:0]           new_w,
                                             input logic [BYTE_LANES-1:0] sel);
    logic [31:0] res;
    res = old_w;
    for (int unsigned b = 0; b < BYTE_LANES; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_wb_ctrl.sv
// Wishbone classic slave in front of a single-port word RAM with combinational read.
// Partial-lane writes run as read-modify-write.
module ram_wb_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned WORD_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [31:0]                 wb_adr_i,
  input  logic [3:0]                  wb_sel_i,
  input  logic [WORD_WIDTH-1:0]       wb_dat_i,
  output logic [WORD_WIDTH-1:0]       wb_dat_o,
  output logic                        wb_ack_o,
  output logic                        wb_err_o,
  output logic [$clog2(DEPTH):0]      ram_addr_o,
  output logic                        ram_en_o,
  output logic                        ram_we_o,
  output logic [WORD_WIDTH-1:0]       ram_din_o,
  input  logic [WORD_WIDTH-1:0]       ram_dout_i
);

  localparam int unsigned AW      = $clog2(DEPTH) + 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  ctrl_state_e           state_q, state_d;
  logic [3:0]            sel_q, sel_d;
  logic [WORD_WIDTH-1:0] dat_q, dat_d;
  logic [WORD_WIDTH-1:0] rdat_q, rdat_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_we_q, ram_we_d;
  logic [AW-1:0]         ram_addr_q, ram_addr_d;
  logic [WORD_WIDTH-1:0] ram_din_q, ram_din_d;

  logic                  req_c;
  logic                  bad_c;
  logic [29:0]           widx_c;

  // Word index relative to the RAM base; BASE_ADDR is taken to be word aligned.
  always_comb begin
    req_c  = wb_cyc_i & wb_stb_i;
    widx_c = wb_adr_i[31:2] - BASE_ADDR[31:2];
    bad_c  = (wb_adr_i < BASE_ADDR) || (widx_c >= DEPTH_W) || (wb_adr_i[1:0] != 2'b00);
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    dat_d      = dat_q;
    rdat_d     = rdat_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    ram_en_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;

    unique case (state_q)
      IDLE: begin
        if (req_c) begin
          sel_d = wb_sel_i;
          dat_d = wb_dat_i;
          if (bad_c) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (!wb_we_i) begin
            state_d    = READ;
            ram_en_d   = 1'b1;
            ram_addr_d = AW'(widx_c);
          end else if (wb_sel_i == 4'hF) begin
            state_d    = WRITE;
            ram_en_d   = 1'b1;
            ram_we_d   = 1'b1;
            ram_addr_d = AW'(widx_c);
            ram_din_d  = wb_dat_i;
          end else if (wb_sel_i == 4'h0) begin
            state_d = ACK;
            ack_d   = 1'b1;
          end else begin
            state_d    = MERGE;
            ram_en_d   = 1'b1;
            ram_addr_d = AW'(widx_c);
          end
        end
      end

      READ: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          state_d = ACK;
          ack_d   = 1'b1;
          rdat_d  = ram_dout_i;
        end
      end

      // Old word is on ram_dout_i this cycle; build the merged word for WRITE.
      MERGE: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          state_d   = WRITE;
          ram_en_d  = 1'b1;
          ram_we_d  = 1'b1;
          ram_din_d = byte_merge(ram_dout_i, dat_q, sel_q);
        end
      end

      // The write lands regardless; a master that has left the cycle gets no ack.
      WRITE: begin
        state_d = ACK;
        ack_d   = wb_cyc_i;
      end

      ACK:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      dat_q      <= '0;
      rdat_q     <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      dat_q      <= dat_d;
      rdat_q     <= rdat_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      ram_en_q   <= ram_en_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
    end
  end

  assign wb_dat_o   = rdat_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign ram_en_o   = ram_en_q;
  assign ram_we_o   = ram_we_q;
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;

endmodule

// File: tb/tb_ram_wb_ctrl.sv
// Scoreboard bench for ram_wb_ctrl: a reference memory predicts every response,
// a monitor pops predictions whenever the controller acks or errors.
module tb_ram_wb_ctrl;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned IW    = 6;
  localparam int unsigned AW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] BASE  = 32'h0000_4000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0]   adr = '0;
  logic [3:0]    sel = '0;
  logic [31:0]   wdat = '0;
  logic [31:0]   rdat;
  logic          ack, err;
  logic [AW-1:0] ram_addr;
  logic          ram_en, ram_we;
  logic [31:0]   ram_din, ram_dout;

  ram_wb_ctrl #(.DEPTH(DEPTH), .WORD_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_sel_i(sel),
    .wb_dat_i(wdat), .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err),
    .ram_addr_o(ram_addr), .ram_en_o(ram_en), .ram_we_o(ram_we),
    .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  always #5 clk = ~clk;

  // Environment RAM: combinational read, synchronous write.
  logic [31:0] mem [DEPTH];
  assign ram_dout = ram_en ? mem[ram_addr[IW-1:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) if (ram_en && ram_we) mem[ram_addr[IW-1:0]] <= ram_din;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_read;

  typedef struct {
    bit          is_err;
    logic [31:0] dat;
    int          lat;
    int          issue;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int en_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) if (ram_en) en_cnt = en_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict the response of one request from the address map and lane rules.
  function automatic exp_t predict(input logic w, input logic [31:0] a,
                                   input logic [3:0] s, input logic [31:0] d);
    exp_t        e;
    int unsigned idx;
    logic [31:0] word;
    e.issue = 0;
    if (a < BASE || ((a - BASE) / 4) >= DEPTH || (a % 4) != 0) begin
      e.is_err = 1'b1;
      e.lat    = 1;
    end else begin
      e.is_err = 1'b0;
      idx = (a - BASE) / 4;
      if (!w) begin
        last_read = ref_mem[idx];
        e.lat = 2;
      end else if (s == 4'hF) begin
        ref_mem[idx] = d;
        e.lat = 2;
      end else if (s == 4'h0) begin
        e.lat = 1;
      end else begin
        word = ref_mem[idx];
        for (int b = 0; b < 4; b++)
          if (s[b]) word[8*b +: 8] = d[8*b +: 8];
        ref_mem[idx] = word;
        e.lat = 3;
      end
    end
    e.dat = last_read;
    return e;
  endfunction

  // Monitor: every completion pulse must match the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (ack || err)) begin
      chk("ack_err_exclusive", 32'(ack & err), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_response", {30'd0, ack, err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_is_err", 32'(err), 32'(e.is_err));
        chk("latency", 32'(cyc_cnt - e.issue), 32'(e.lat));
        chk("wb_dat_o", rdat, e.dat);
      end
    end
  end

  // Issue one request, hold it until a response or timeout, then release.
  task automatic wb_req(input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    exp_t e;
    bit   done;
    e = predict(w, a, s, d);
    e.issue = cyc_cnt;
    exp_q.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      if (ack || err) done = 1'b1;
    end
    if (!done) begin
      chk("response_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic chk_quiet_outputs(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_dat"}, rdat, 32'd0);
    chk({tag, "_en"}, 32'(ram_en), 32'd0);
    chk({tag, "_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_din"}, ram_din, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0)      return BASE - 32'(4 * $urandom_range(1, 8));
    else if (r == 1) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
    else if (r == 2) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
    else             return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    int          e0;
    logic [31:0] w;
    logic [3:0]  s;

    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      mem[i] = w;
      ref_mem[i] = w;
    end
    last_read = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet_outputs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Full write then read back
    wb_req(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
    wb_req(1'b0, BASE + 32'h10, 4'h0, 32'h0);
    chk("read_back", rdat, 32'hDEAD_BEEF);

    // Read-modify-write with alternating lanes
    wb_req(1'b1, BASE + 32'h20, 4'hF, 32'h1122_3344);
    wb_req(1'b1, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD);
    wb_req(1'b0, BASE + 32'h20, 4'hA, 32'h0);
    chk("merge_result", rdat, 32'h11BB_33DD);

    // Out-of-range and misaligned: error only, RAM untouched
    e0 = en_cnt;
    wb_req(1'b0, BASE + 32'(4 * DEPTH), 4'hF, 32'h0);
    wb_req(1'b0, BASE + 32'h2, 4'hF, 32'h0);
    wb_req(1'b1, BASE - 32'h4, 4'hF, 32'h0);
    chk("err_no_ram_en", 32'(en_cnt), 32'(e0));

    // sel=0 write: ack after one cycle, no RAM access
    e0 = en_cnt;
    wb_req(1'b1, BASE + 32'h20, 4'h0, 32'hFFFF_FFFF);
    chk("sel0_no_ram_en", 32'(en_cnt), 32'(e0));
    chk("sel0_word_kept", mem[8], 32'h11BB_33DD);

    // Partial write abandoned during MERGE
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h20; sel = 4'b0011; wdat = 32'h5555_5555;
    @(posedge clk); #1 cyc = 1'b0; stb = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_word_kept", mem[8], ref_mem[8]);

    // Reset in the middle of a read
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("read_en_before_reset", 32'(ram_en), 32'd1);
    @(posedge clk); #1 rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    last_read = '0;
    @(negedge clk);
    chk_quiet_outputs("midreset");
    repeat (2) @(posedge clk); #1;
    wb_req(1'b0, BASE + 32'h10, 4'h0, 32'h0);
    chk("read_after_reset", rdat, 32'hDEAD_BEEF);

    // Randomised traffic, including back-to-back requests
    for (int n = 0; n < 300; n++) begin
      s = $urandom_range(0, 3) == 0 ? 4'hF : ($urandom_range(0, 5) == 0 ? 4'h0 : 4'($urandom));
      wb_req(1'($urandom), rand_addr(), s, $urandom);
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < DEPTH; i += 7) chk("final_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
